axis_fraction_divider_sx: RTL and testbench
===========================================

// Module: axis_fraction_divider_sx
// PURPOSE
//  Pipelined fixed-point divider: q = (dividend << FRACTIONAL_WIDTH) / divisor, one result per clock.
//  Successor to the unsigned fraction divider: adds signed mode, remainder output, saturation and
//  overflow/zero flags, tlast pass-through and full AXI-Stream backpressure (tready).
//  Sits between the sample-math datapath and downstream AXIS consumers.
// PARAMETERS
//  DIVISOR_WIDTH       16  divisor bits (DW)
//  DIVIDEND_WIDTH      16  dividend bits (VW)
//  FRACTIONAL_WIDTH     8  fraction bits appended to the quotient (F); N = VW+F
//  SIGNED               1  1: two's-complement operands/results; 0: unsigned
//  REMAINDER_OUT        1  1: remainder appended to tdata
//  USER_WIDTH           0  dividend tuser bits carried to the output (0 = none)
//  COMB_FF_INTERVAL     2  register after every Kth iteration stage (K >= 1)
// PORTS
//  aclk                     in   1       clock
//  aresetn                  in   1       asynchronous active-low reset
//  aclken                   in   1       clock enable; 0 freezes every register
//  s_axis_divisor_tvalid    in   1       divisor valid
//  s_axis_divisor_tready    out  1       divisor ready
//  s_axis_divisor_tdata     in   A8(DW)  divisor in [DW-1:0]; upper pad bits ignored
//  s_axis_dividend_tvalid   in   1       dividend valid
//  s_axis_dividend_tready   out  1       dividend ready
//  s_axis_dividend_tdata    in   A8(VW)  dividend in [VW-1:0]
//  s_axis_dividend_tuser    in   max(USER_WIDTH,1)  sideband; ignored when USER_WIDTH=0
//  s_axis_dividend_tlast    in   1       packet boundary
//  m_axis_dout_tvalid       out  1       result valid
//  m_axis_dout_tready       in   1       result ready
//  m_axis_dout_tdata        out  A8(N)+REMAINDER_OUT*A8(DW)  {rem, quotient}; A8(x) = x rounded up to a multiple of 8
//  m_axis_dout_tuser        out  2+USER_WIDTH  {user, overflow, div_by_zero}
//  m_axis_dout_tlast        out  1       tlast of the matching dividend
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids, m_axis_dout_tvalid, tdata, tuser and
//    tlast = 0. In-flight operations are discarded; no partial result ever appears after reset.
//  - stall = m_axis_dout_tvalid & ~m_axis_dout_tready. Every register advances only when
//    aclken & ~stall; otherwise all stages hold, bubbles included.
//  - Join: s_axis_divisor_tready = aclken & ~stall & s_axis_dividend_tvalid, and symmetric for the
//    dividend. Transfer occurs only when both valids are high in the same cycle. A lone valid
//    waits and is never consumed.
//  - tready may depend on the other channel's tvalid. No tvalid depends on any tready.
//  - Pipeline: input register (abs/sign capture), N restoring iteration stages (MSB first,
//    FF after stage i when (i+1)%K==0), output register (sign fix, saturate).
//    Latency L = 2 + floor(N/K) accepted-to-valid cycles without stall. Defaults: N=24, L=14.
//  - Arithmetic: magnitudes |a|,|b|. Quotient magnitude Qm = floor(|a|*2^F / |b|). Rm = remainder.
//    Quotient sign = sa^sb; remainder takes the dividend sign (truncation toward zero).
//    SIGNED=0: sa=sb=0.
//  - Quotient field: N bits, sign-extended (SIGNED) or zero-padded to A8(N).
//    Remainder field: DW bits, likewise.
//  - Overflow (SIGNED=1): positive with Qm >= 2^(N-1), or negative with Qm > 2^(N-1).
//    Quotient saturates to 2^(N-1)-1 or -2^(N-1); tuser[1]=1; remainder field = 0.
//    SIGNED=0 never overflows.
//  - Divide by zero (b==0): tuser[0]=1, tuser[1]=0, remainder = 0. Quotient = max positive
//    (unsigned: all ones) if a>=0, else -2^(N-1).
//  - tuser[2+:USER_WIDTH] and tlast travel with their operand through every stage.
//  - Output holds tdata/tuser/tlast stable while tvalid & ~tready. With tready=1 the block
//    sustains 1 result/clk.
// TESTING (defaults: DW=VW=16, F=8, SIGNED=1, K=2)
//  1. 7 / 2 -> q=0x000380, rem=0x0000, tuser=0, tvalid exactly 14 cycles after accept.
//  2. 7 / 3 -> q=0x000255, rem=1.
//     -7 / 3 -> q=0xFFFDAB, rem=0xFFFF.
//     -7 / 2 -> q=0xFFFC80.
//  3. 5 / 0 -> q=0x7FFFFF, tuser[0]=1.
//     -5 / 0 -> q=0x800000, tuser[0]=1.
//  4. 0x8000 / 0xFFFF -> q=0x7FFFFF, tuser[1]=1.
//     0x8000 / 1 -> q=0x800000, tuser[1]=0.
//  5. Random back-to-back stream with m_tready toggling 50% and aclken toggling
//     -> results match golden model in order; no drops or duplicates; tdata stable while stalled.
//  6. Divisor valid alone for 5 cycles, then dividend -> exactly one result.
//     Assert aresetn low mid-stream -> tvalid=0 immediately; no stale results after release.

Source files
------------

// File: rtl/axis_fraction_divider_sx.sv
// Pipelined restoring fixed-point divider: q = (dividend << F) / divisor, one result per clock.
// Signed/unsigned operands, remainder, saturation, overflow/div-by-zero flags and AXIS backpressure.
module axis_fraction_divider_sx #(
  parameter int DIVISOR_WIDTH    = 16,
  parameter int DIVIDEND_WIDTH   = 16,
  parameter int FRACTIONAL_WIDTH = 8,
  parameter int SIGNED           = 1,
  parameter int REMAINDER_OUT    = 1,
  parameter int USER_WIDTH       = 0,
  parameter int COMB_FF_INTERVAL = 2,
  localparam int DW  = DIVISOR_WIDTH,
  localparam int VW  = DIVIDEND_WIDTH,
  localparam int F   = FRACTIONAL_WIDTH,
  localparam int N   = VW + F,
  localparam int K   = COMB_FF_INTERVAL,
  localparam int NR  = N / K,
  localparam int NRA = (NR > 0) ? NR : 1,
  localparam int DWA = ((DW + 7) / 8) * 8,
  localparam int VWA = ((VW + 7) / 8) * 8,
  localparam int QA  = ((N + 7) / 8) * 8,
  localparam int TDW = QA + ((REMAINDER_OUT != 0) ? DWA : 0),
  localparam int UW  = (USER_WIDTH > 0) ? USER_WIDTH : 1,
  localparam int TUW = 2 + USER_WIDTH
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           aclken,
  input  logic           s_axis_divisor_tvalid,
  output logic           s_axis_divisor_tready,
  input  logic [DWA-1:0] s_axis_divisor_tdata,
  input  logic           s_axis_dividend_tvalid,
  output logic           s_axis_dividend_tready,
  input  logic [VWA-1:0] s_axis_dividend_tdata,
  input  logic [UW-1:0]  s_axis_dividend_tuser,
  input  logic           s_axis_dividend_tlast,
  output logic           m_axis_dout_tvalid,
  input  logic           m_axis_dout_tready,
  output logic [TDW-1:0] m_axis_dout_tdata,
  output logic [TUW-1:0] m_axis_dout_tuser,
  output logic           m_axis_dout_tlast
);

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [UW-1:0] user;
    logic          sa;
    logic          sb;
    logic          bz;
    logic [DW-1:0] d;
    logic [DW-1:0] r;
    logic [N-1:0]  q;
    logic [N-1:0]  num;
  } stage_t;

  // One restoring step: shift the next numerator bit into the partial remainder.
  function automatic stage_t iterate(input stage_t s);
    stage_t     o;
    logic [DW:0] t;
    logic        qbit;
    o = s;
    t = {s.r, s.num[N-1]};
    if (t >= {1'b0, s.d}) begin
      t    = t - {1'b0, s.d};
      qbit = 1'b1;
    end else begin
      qbit = 1'b0;
    end
    o.r   = t[DW-1:0];
    o.q   = {s.q[N-2:0], qbit};
    o.num = {s.num[N-2:0], 1'b0};
    return o;
  endfunction

  function automatic logic [QA-1:0] ext_q(input logic [N-1:0] v);
    logic [QA-1:0] o;
    o        = {QA{(SIGNED != 0) && v[N-1]}};
    o[N-1:0] = v;
    return o;
  endfunction

  function automatic logic [DWA-1:0] ext_r(input logic [DW-1:0] v);
    logic [DWA-1:0] o;
    o         = {DWA{(SIGNED != 0) && v[DW-1]}};
    o[DW-1:0] = v;
    return o;
  endfunction

  logic           advance_s;
  logic           accept_s;
  logic [VW-1:0]  a_s;
  logic [DW-1:0]  b_s;
  stage_t         in_d_s;
  stage_t         in_r;
  stage_t         chain_s;
  stage_t         fin_s;
  stage_t         pipe_d_s [0:NRA-1];
  stage_t         pipe_r   [0:NRA-1];
  logic           neg_q_s;
  logic [N-1:0]   lim_s;
  logic [N-1:0]   q_s;
  logic [DW-1:0]  r_s;
  logic           ovf_s;
  logic           dz_s;
  logic [TDW-1:0] tdata_d_s;
  logic [TUW-1:0] tuser_d_s;

  assign advance_s              = aclken & ~(m_axis_dout_tvalid & ~m_axis_dout_tready);
  assign s_axis_divisor_tready  = advance_s & s_axis_dividend_tvalid;
  assign s_axis_dividend_tready = advance_s & s_axis_divisor_tvalid;
  assign accept_s               = advance_s & s_axis_divisor_tvalid & s_axis_dividend_tvalid;

  // Operand capture: magnitudes and signs of the joined pair.
  always_comb begin
    a_s           = s_axis_dividend_tdata[VW-1:0];
    b_s           = s_axis_divisor_tdata[DW-1:0];
    in_d_s        = '0;
    in_d_s.valid  = accept_s;
    in_d_s.last   = s_axis_dividend_tlast;
    in_d_s.user   = s_axis_dividend_tuser;
    in_d_s.sa     = (SIGNED != 0) && a_s[VW-1];
    in_d_s.sb     = (SIGNED != 0) && b_s[DW-1];
    in_d_s.bz     = (b_s == {DW{1'b0}});
    in_d_s.d      = in_d_s.sb ? ({DW{1'b0}} - b_s) : b_s;
    in_d_s.num    = {(in_d_s.sa ? ({VW{1'b0}} - a_s) : a_s), {F{1'b0}}};
  end

  // Iteration chain, cut by a register after every K-th step.
  always_comb begin
    for (int j = 0; j < NRA; j++) begin
      pipe_d_s[j] = '0;
    end
    chain_s = in_r;
    for (int i = 0; i < N; i++) begin
      if ((i > 0) && ((i % K) == 0)) begin
        chain_s = pipe_r[i / K - 1];
      end else begin
        chain_s = chain_s;
      end
      chain_s = iterate(chain_s);
      if (((i + 1) % K) == 0) begin
        pipe_d_s[(i + 1) / K - 1] = chain_s;
      end else begin
        pipe_d_s[0] = pipe_d_s[0];
      end
    end
    if ((N % K) == 0) begin
      fin_s = pipe_r[NRA-1];
    end else begin
      fin_s = chain_s;
    end
  end

  // Sign restoration, saturation and flag generation for the output register.
  always_comb begin
    neg_q_s = fin_s.sa ^ fin_s.sb;
    lim_s   = {1'b1, {(N-1){1'b0}}};
    ovf_s   = 1'b0;
    dz_s    = 1'b0;
    if (fin_s.bz) begin
      dz_s = 1'b1;
      r_s  = {DW{1'b0}};
      if (SIGNED != 0) begin
        q_s = fin_s.sa ? lim_s : ~lim_s;
      end else begin
        q_s = {N{1'b1}};
      end
    end else if ((SIGNED != 0) && (neg_q_s ? (fin_s.q > lim_s) : (fin_s.q >= lim_s))) begin
      ovf_s = 1'b1;
      q_s   = neg_q_s ? lim_s : ~lim_s;
      r_s   = {DW{1'b0}};
    end else begin
      q_s = neg_q_s ? ({N{1'b0}} - fin_s.q) : fin_s.q;
      r_s = fin_s.sa ? ({DW{1'b0}} - fin_s.r) : fin_s.r;
    end
    // Remainder sits above the quotient, so narrowing drops it when it is not wanted.
    tdata_d_s = TDW'({ext_r(r_s), ext_q(q_s)});
    tuser_d_s = TUW'({fin_s.user, ovf_s, dz_s});
  end

  // Pipeline registers: everything advances together or holds together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_r <= '0;
      for (int j = 0; j < NRA; j++) begin
        pipe_r[j] <= '0;
      end
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tuser  <= '0;
      m_axis_dout_tlast  <= 1'b0;
    end else if (advance_s) begin
      in_r <= in_d_s;
      for (int j = 0; j < NRA; j++) begin
        pipe_r[j] <= pipe_d_s[j];
      end
      m_axis_dout_tvalid <= fin_s.valid;
      m_axis_dout_tdata  <= tdata_d_s;
      m_axis_dout_tuser  <= tuser_d_s;
      m_axis_dout_tlast  <= fin_s.last;
    end
  end

endmodule

// File: tb/tb_axis_fraction_divider_sx.sv
// Bench for axis_fraction_divider_sx at default parameters: integer-arithmetic reference model,
// scoreboard queue, per-cycle handshake/stability checks and directed plus random stimulus.
module tb_axis_fraction_divider_sx;

  localparam longint QMAX = 64'sd8388607;
  localparam longint QMIN = -64'sd8388608;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken = 1'b1;
  logic        dvs_v = 1'b0;
  logic [15:0] dvs_d = 16'h0000;
  logic        dvd_v = 1'b0;
  logic [15:0] dvd_d = 16'h0000;
  logic [0:0]  dvd_user = 1'b0;
  logic        dvd_last = 1'b0;
  logic        m_tready = 1'b1;
  logic        dvs_r;
  logic        dvd_r;
  logic        m_v;
  logic [39:0] m_d;
  logic [1:0]  m_u;
  logic        m_l;

  int          nvec = 0;
  int          nfail = 0;
  int          out_cnt = 0;
  logic [42:0] exp_q[$];
  logic [42:0] held;
  logic        held_v = 1'b0;
  logic        stall_m;
  logic        acc_r;
  int          k;
  int          cnt0;
  logic [15:0] va [0:6];
  logic [15:0] vb [0:6];

  axis_fraction_divider_sx dut (
    .aclk                   (clk),
    .aresetn                (aresetn),
    .aclken                 (aclken),
    .s_axis_divisor_tvalid  (dvs_v),
    .s_axis_divisor_tready  (dvs_r),
    .s_axis_divisor_tdata   (dvs_d),
    .s_axis_dividend_tvalid (dvd_v),
    .s_axis_dividend_tready (dvd_r),
    .s_axis_dividend_tdata  (dvd_d),
    .s_axis_dividend_tuser  (dvd_user),
    .s_axis_dividend_tlast  (dvd_last),
    .m_axis_dout_tvalid     (m_v),
    .m_axis_dout_tready     (m_tready),
    .m_axis_dout_tdata      (m_d),
    .m_axis_dout_tuser      (m_u),
    .m_axis_dout_tlast      (m_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: truncating signed division of a*256 by b, then saturation rules.
  function automatic logic [42:0] model(input logic [15:0] a, input logic [15:0] b, input logic last);
    longint sa, sb, q, r;
    logic   ovf, dz;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    dz  = 1'b0;
    if (sb == 64'sd0) begin
      dz = 1'b1;
      q  = (sa >= 64'sd0) ? QMAX : QMIN;
      r  = 64'sd0;
    end else begin
      q = (sa * 64'sd256) / sb;
      r = (sa * 64'sd256) % sb;
      if (q > QMAX || q < QMIN) begin
        ovf = 1'b1;
        q   = (q > 64'sd0) ? QMAX : QMIN;
        r   = 64'sd0;
      end
    end
    return {r[15:0], q[23:0], ovf, dz, last};
  endfunction

  // Scoreboard: ready rule, accept capture, hold stability and in-order result checks.
  always @(negedge clk) begin
    if (aresetn) begin
      stall_m = m_v & ~m_tready;
      chk("divisor_tready", dvs_r, aclken & ~stall_m & dvd_v);
      chk("dividend_tready", dvd_r, aclken & ~stall_m & dvs_v);
      if (dvs_v && dvd_v && dvs_r && dvd_r) exp_q.push_back(model(dvd_d, dvs_d, dvd_last));
      if (held_v) begin
        chk("hold_tvalid", m_v, 1'b1);
        chk("hold_payload", {m_d, m_u, m_l}, held);
      end
      held_v = m_v & ~(m_tready & aclken);
      held   = {m_d, m_u, m_l};
      if (m_v && m_tready && aclken) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {m_d, m_u, m_l}, 64'd0);
          nvec--; if (!({m_d, m_u, m_l} !== 64'd0)) begin nvec++; nfail++; $display("FAIL unexpected_result: actual %0h required none", {m_d, m_u, m_l}); end else nvec++;
        end else begin
          chk("dout", {m_d, m_u, m_l}, exp_q.pop_front());
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic last);
    logic ok;
    dvs_d = b; dvd_d = a; dvd_last = last;
    dvs_v = 1'b1; dvd_v = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = dvs_r & dvd_r;
      @(posedge clk); #1;
    end
    dvs_v = 1'b0; dvd_v = 1'b0; dvd_last = 1'b0;
    if (!ok) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: actual no accept required accept within 50 cycles");
    end
  endtask

  task automatic drain(input string name);
    aclken = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk(name, exp_q.size(), 64'd0);
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    va[0] = 16'd7;    vb[0] = 16'd3;
    va[1] = 16'hFFF9; vb[1] = 16'd3;
    va[2] = 16'hFFF9; vb[2] = 16'd2;
    va[3] = 16'd5;    vb[3] = 16'd0;
    va[4] = 16'hFFFB; vb[4] = 16'd0;
    va[5] = 16'h8000; vb[5] = 16'hFFFF;
    va[6] = 16'h8000; vb[6] = 16'd1;

    #12;
    chk("reset_tvalid", m_v, 1'b0);
    chk("reset_tdata", m_d, 40'h0);
    chk("reset_tuser", m_u, 2'b00);
    chk("reset_tlast", m_l, 1'b0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Hand-computed anchors for the reference model.
    chk("pin_7_2",     model(16'd7,    16'd2,    1'b0), {16'h0000, 24'h000380, 2'b00, 1'b0});
    chk("pin_7_3",     model(16'd7,    16'd3,    1'b0), {16'h0001, 24'h000255, 2'b00, 1'b0});
    chk("pin_m7_3",    model(16'hFFF9, 16'd3,    1'b0), {16'hFFFF, 24'hFFFDAB, 2'b00, 1'b0});
    chk("pin_m7_2",    model(16'hFFF9, 16'd2,    1'b0), {16'h0000, 24'hFFFC80, 2'b00, 1'b0});
    chk("pin_5_0",     model(16'd5,    16'd0,    1'b0), {16'h0000, 24'h7FFFFF, 2'b01, 1'b0});
    chk("pin_m5_0",    model(16'hFFFB, 16'd0,    1'b0), {16'h0000, 24'h800000, 2'b01, 1'b0});
    chk("pin_min_m1",  model(16'h8000, 16'hFFFF, 1'b0), {16'h0000, 24'h7FFFFF, 2'b10, 1'b0});
    chk("pin_min_1",   model(16'h8000, 16'd1,    1'b1), {16'h0000, 24'h800000, 2'b00, 1'b1});

    // Latency from accept cycle to first visible tvalid.
    send_one(16'd7, 16'd2, 1'b1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_v) begin k = i; break; end
    end
    chk("latency", k, 64'd14);
    drain("drain_latency");

    for (int i = 0; i < 7; i++) send_one(va[i], vb[i], 1'(i % 2));
    drain("drain_directed");

    // A lone divisor must wait, then join exactly once.
    cnt0 = out_cnt;
    dvs_d = 16'd3; dvs_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lone_divisor_tready", dvs_r, 1'b0);
      @(posedge clk); #1;
    end
    send_one(16'd100, 16'd3, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("lone_result_count", out_cnt - cnt0, 64'd1);

    // Reset while operations are in flight.
    for (int i = 0; i < 4; i++) send_one(16'(i + 11), 16'd5, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_tvalid", m_v, 1'b0);
    chk("midreset_tdata", m_d, 40'h0);
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) send_one(16'(200 + i), 16'hFFF0, 1'b1);
    drain("drain_after_reset");

    // Random stream with backpressure and clock-enable gaps.
    for (int cyc = 0; cyc < 500; cyc++) begin
      aclken   = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      if (!dvs_v && $urandom_range(0, 3) != 0) begin dvs_v = 1'b1; dvs_d = rand_val(); end
      if (!dvd_v && $urandom_range(0, 3) != 0) begin
        dvd_v = 1'b1; dvd_d = rand_val(); dvd_last = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      acc_r = dvs_v & dvd_v & dvs_r & dvd_r;
      @(posedge clk); #1;
      if (acc_r) begin dvs_v = 1'b0; dvd_v = 1'b0; end
    end
    dvs_v = 1'b0; dvd_v = 1'b0;
    drain("drain_random");
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
